// File: rtl/world_engine.sv
// world_engine: grid-world simulator for the pipe-cleaning robot (map, pose, sensors, step handshake).
// Optional feature macro: COLLISION_CHECK_EN blocks moves into walls/barriers and raises a sticky fault.
module world_engine #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int REMOVE_CYCLES = 3,
  parameter int START_ROW     = 1,
  parameter int START_COL     = 1,
  parameter int START_DIR     = 0,
  localparam int RW           = $clog2(ROWS + 1),
  localparam int CW           = $clog2(COLS + 1),
  localparam int AW           = $clog2(ROWS * COLS),
  localparam int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  output logic             ready,
  output logic             sens_valid,
  output logic             head,
  output logic             left,
  output logic             under,
  output logic             barrier,
  input  logic             cmd_valid,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
  output logic             done,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [2:0]       load_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [2:0]       rd_cell,
  output logic [RW-1:0]    robot_row,
  output logic [CW-1:0]    robot_col,
  output logic [1:0]       robot_dir,
  output logic [CNT_W-1:0] removed_count,
  output logic             fault
);
  localparam int CELLS = ROWS * COLS;
  localparam int RCW   = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SENSE = 2'd1, WAIT_CMD = 2'd2, APPLY = 2'd3} state_t;

  function automatic logic [1:0] rot_left(input logic [1:0] d);
    case (d)
      2'b00:   rot_left = 2'b11;
      2'b01:   rot_left = 2'b10;
      2'b10:   rot_left = 2'b00;
      default: rot_left = 2'b01;
    endcase
  endfunction

  function automatic logic nb_in(input logic [1:0] d, input logic [RW-1:0] r, input logic [CW-1:0] c);
    case (d)
      2'b00:   nb_in = (r > RW'(1));
      2'b01:   nb_in = (r < RW'(ROWS));
      2'b10:   nb_in = (c < CW'(COLS));
      default: nb_in = (c > CW'(1));
    endcase
  endfunction

  function automatic logic [RW-1:0] nb_row(input logic [1:0] d, input logic [RW-1:0] r);
    case (d)
      2'b00:   nb_row = r - RW'(1);
      2'b01:   nb_row = r + RW'(1);
      default: nb_row = r;
    endcase
  endfunction

  function automatic logic [CW-1:0] nb_col(input logic [1:0] d, input logic [CW-1:0] c);
    case (d)
      2'b10:   nb_col = c + CW'(1);
      2'b11:   nb_col = c - CW'(1);
      default: nb_col = c;
    endcase
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    cell_addr = AW'((int'(r) - 1) * COLS + (int'(c) - 1));
  endfunction

  state_t           state_r, state_nx_s;
  logic [2:0]       map_r [0:CELLS-1];
  logic [RW-1:0]    row_r;
  logic [CW-1:0]    col_r;
  logic [1:0]       dir_r, left_dir_s;
  logic             head_r, left_r, under_r, barrier_r, sens_valid_r, done_r;
  logic             fr_q_r, tn_q_r, rm_q_r;
  logic [RCW-1:0]   rm_cnt_r;
  logic [CNT_W-1:0] removed_r;
  logic [2:0]       rd_cell_r;
  logic             ready_s, sense_s, apply_s, load_wr_s;
  logic             ahead_in_s, left_in_s, hit_s, clear_s, blocked_s;
  logic [AW-1:0]    ahead_addr_s, left_addr_s;
  logic [2:0]       ahead_cell_s, left_cell_s, here_cell_s;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state logic; a load in IDLE takes precedence over step
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:     if (step && !load_en) state_nx_s = SENSE; else state_nx_s = IDLE;
      SENSE:    state_nx_s = WAIT_CMD;
      WAIT_CMD: if (cmd_valid) state_nx_s = APPLY; else state_nx_s = WAIT_CMD;
      APPLY:    state_nx_s = IDLE;
      default:  state_nx_s = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    ready_s   = (state_r == IDLE);
    sense_s   = (state_r == SENSE);
    apply_s   = (state_r == APPLY);
    load_wr_s = ready_s && load_en && (int'(load_addr) < CELLS);
  end

  // Neighbourhood lookup and apply-phase decisions, all from the pre-move pose
  always_comb begin
    left_dir_s   = rot_left(dir_r);
    ahead_in_s   = nb_in(dir_r, row_r, col_r);
    left_in_s    = nb_in(left_dir_s, row_r, col_r);
    ahead_addr_s = cell_addr(nb_row(dir_r, row_r), nb_col(dir_r, col_r));
    left_addr_s  = cell_addr(nb_row(left_dir_s, row_r), nb_col(left_dir_s, col_r));
    ahead_cell_s = ahead_in_s ? map_r[ahead_addr_s] : 3'd0;
    left_cell_s  = left_in_s ? map_r[left_addr_s] : 3'd0;
    here_cell_s  = map_r[cell_addr(row_r, col_r)];
    hit_s        = apply_s && rm_q_r && (rm_cnt_r == RCW'(REMOVE_CYCLES - 1));
    clear_s      = hit_s && ahead_in_s && (ahead_cell_s == 3'd2);
`ifdef COLLISION_CHECK_EN
    blocked_s    = apply_s && fr_q_r && (head_r || barrier_r);
`else
    blocked_s    = 1'b0;
`endif
  end

  // Sensor capture in SENSE; sens_valid marks entry into WAIT_CMD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {head_r, left_r, under_r, barrier_r} <= 4'b0000;
      sens_valid_r <= 1'b0;
    end else begin
      sens_valid_r <= sense_s;
      if (sense_s) begin
        head_r    <= !ahead_in_s || (ahead_cell_s == 3'd1);
        left_r    <= !left_in_s || (left_cell_s == 3'd1);
        under_r   <= (here_cell_s == 3'd7);
        barrier_r <= ahead_in_s && (ahead_cell_s == 3'd2);
      end
    end
  end

  // Command latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {fr_q_r, tn_q_r, rm_q_r} <= 3'b000;
    end else if ((state_r == WAIT_CMD) && cmd_valid) begin
      {fr_q_r, tn_q_r, rm_q_r} <= {front, turn, remove};
    end
  end

  // Pose, removal progress and statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_r     <= RW'(START_ROW);
      col_r     <= CW'(START_COL);
      dir_r     <= 2'(START_DIR);
      rm_cnt_r  <= '0;
      removed_r <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= apply_s;
      if (apply_s) begin
        if (!blocked_s && fr_q_r && ahead_in_s) begin
          row_r <= nb_row(dir_r, row_r);
          col_r <= nb_col(dir_r, col_r);
        end else if (!blocked_s && !fr_q_r && tn_q_r) begin
          dir_r <= left_dir_s;
        end
        if (!rm_q_r || hit_s) rm_cnt_r <= '0;
        else                  rm_cnt_r <= rm_cnt_r + RCW'(1);
        if (clear_s && (removed_r != {CNT_W{1'b1}})) removed_r <= removed_r + CNT_W'(1);
      end
    end
  end

  // Map storage keeps its contents across reset
  always_ff @(posedge clock) begin
    if (load_wr_s)    map_r[load_addr]    <= load_data;
    else if (clear_s) map_r[ahead_addr_s] <= 3'd0;
  end

  // Graphics read port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_cell_r <= 3'd0;
    else        rd_cell_r <= (int'(rd_addr) < CELLS) ? map_r[rd_addr] : 3'd0;
  end

`ifdef COLLISION_CHECK_EN
  logic fault_r;
  // Sticky collision flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         fault_r <= 1'b0;
    else if (blocked_s) fault_r <= 1'b1;
  end
  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  assign ready         = ready_s;
  assign sens_valid    = sens_valid_r;
  assign head          = head_r;
  assign left          = left_r;
  assign under         = under_r;
  assign barrier       = barrier_r;
  assign done          = done_r;
  assign rd_cell       = rd_cell_r;
  assign robot_row     = row_r;
  assign robot_col     = col_r;
  assign robot_dir     = dir_r;
  assign removed_count = removed_r;
endmodule

// File: doc/world_engine.md
Name: world_engine

Overview:
- Parametrised environment simulator for the pipe-cleaning robot: holds a ROWS x COLS cell map, robot position and heading.
- Produces the head/left/under/barrier sensor set and applies front/turn/remove commands through a explicit step handshake, replacing free-running half-clock updates.
- Adds map load, a graphics read port, a configurable trash-removal duration and removal statistics.

Parameters:
- ROWS, 10, map rows, indexed 1..ROWS
- COLS, 20, map columns, indexed 1..COLS
- REMOVE_CYCLES, 3, consecutive remove commands needed to clear a barrier (>=1)
- START_ROW, 1, reset row
- START_COL, 1, reset column
- START_DIR, 0, reset heading (00 north, 01 south, 10 east, 11 west)
- Derived: RW=$clog2(ROWS+1), CW=$clog2(COLS+1), AW=$clog2(ROWS*COLS), CNT_W=16

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- step  in  1  start one world step; sampled only when ready=1
- ready  out  1  engine idle, accepts step or load
- sens_valid  out  1  one-cycle pulse; head/left/under/barrier valid from this cycle until next step
- head, left, under, barrier  out  1 each  sensor values
- cmd_valid  in  1  robot command valid; sampled only in WAIT_CMD
- front, turn, remove  in  1 each  robot command bits
- done  out  1  one-cycle pulse after command applied
- load_en  in  1  map write strobe
- load_addr  in  AW  cell address = (row-1)*COLS + (col-1)
- load_data  in  3  cell code
- rd_addr  in  AW  graphics read address
- rd_cell  out  3  cell code at rd_addr, 1-cycle latency
- robot_row  out  RW  current row
- robot_col  out  CW  current column
- robot_dir  out  2  current heading
- removed_count  out  CNT_W  barriers cleared since reset, saturating
- fault  out  1  sticky illegal-move flag (macro only)

Behaviour:
- Cell codes: 0 empty, 1 wall, 2 barrier (trash), 7 dirt-under; others treated as empty.
- Reset (async, active-low): state IDLE, ready=1, robot_row/col/dir = START_*, sensors 0, sens_valid=0, done=0, removed_count=0, remove counter 0, fault=0, rd_cell=0. Map contents retained (RAM-style).
- FSM: IDLE -> (step) SENSE -> WAIT_CMD -> (cmd_valid) APPLY -> IDLE.
- IDLE: ready=1. load_en writes map; writes with load_addr >= ROWS*COLS ignored. load_en together with step: load wins, step ignored.
- SENSE: one cycle. Sensors registered from current position/heading; sens_valid pulses on the cycle of entry into WAIT_CMD.
- "Ahead" / "left" are relative to heading. Left-hand neighbours: north->west, south->east, east->north, west->south.
- head = ahead out of bounds OR ahead cell == 1.
- left = left neighbour out of bounds OR left cell == 1.
- under = current cell == 7.
- barrier = ahead in bounds AND ahead cell == 2.
- WAIT_CMD: holds indefinitely; load_en and step ignored.
- APPLY (one cycle, done pulses on exit):
  - front=1: move one cell ahead. Never moves out of bounds: position held when ahead is out of bounds.
  - front=0, turn=1: rotate left (north->west->south->east->north).
  - front has priority over turn.
  - remove=1: remove counter increments. On reaching REMOVE_CYCLES, the cell ahead of the pre-move position/heading is cleared to 0 (if in bounds and == 2), counter resets to 0, removed_count +1 (saturates at all-ones).
  - remove=0: remove counter resets to 0.
  - A load never occurs in the same cycle as APPLY.
- Total latency: step to sens_valid = 2 cycles; cmd_valid to done = 2 cycles.
- rd_cell = map[rd_addr] registered every cycle regardless of state; out-of-range address returns 0.
- Reset mid-operation returns to IDLE; any partial remove count is discarded.

Optional Feature:
- Macro COLLISION_CHECK_EN.
- Defined: in APPLY, front=1 while the latched head or barrier = 1 suppresses the move (turn is not applied either), and fault is set sticky until reset.
- Undefined: fault is tied 0; front moves into wall/barrier cells when in bounds. The out-of-bounds hold still applies.

Test Plan:
- Reset with START 1/1/east, empty map; step -> sens_valid after 2 cycles, head=0, left=1 (row-1 is out of bounds); cmd front -> done, robot_col=2.
- Load cell (1,3)=2, robot at (1,2) east; three steps with remove=1 -> after third done, rd_cell at addr 2 = 0, removed_count=1.
- Two remove steps, one step with remove=0, one remove step -> barrier still 2, removed_count=0.
- Robot at (10,20) heading south, cmd front -> robot_row stays 10; cmd turn -> dir=east; step -> head=1.
- With COLLISION_CHECK_EN, wall ahead, cmd front+turn -> position and dir unchanged, fault=1 until reset. Without the macro, the robot enters the wall cell and fault=0.
- Assert reset in WAIT_CMD -> ready=1 immediately, position=START, map contents unchanged via rd_addr readback.
